// File: rtl/dec_pkg.sv
// Shared decode definitions for the 2-wide RV32I decode/issue stage.
// Contents: base opcode constants, ALU op / memory size / branch condition
// encodings, the packed micro-op layout (uop_t) and its width UOP_W.
package dec_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_SRA  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_NOP  = 4'd15
    } alu_op_t;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_t;

    // Branch condition is the raw branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU).
    typedef logic [2:0] br_cond_t;

    typedef struct packed {
        alu_op_t   alu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic      rs2_en;
        logic      reg_write_en;
        logic      branch_en;
        br_cond_t  br_cond;
        logic      mem_read_en;
        logic      mem_write_en;
        mem_size_t mem_size;
        logic      illegal;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    // Loads and stores can only execute in lane B.
    function automatic logic is_mem_op(input uop_t u);
        return u.mem_read_en | u.mem_write_en;
    endfunction

endpackage

// File: rtl/rv32_inst_decode.sv
// Combinational single-instruction RV32I decoder (R/I/load/store/branch).
// Ports:
//   inst  in   32    raw instruction word
//   uop   out  uop_t decoded micro-op; illegal encodings give an all-zero
//                    uop with alu_op=NOP and illegal=1
//   imm   out  XLEN  sign-extended I/S/B immediate (0 for R-type/illegal)
module rv32_inst_decode
    import dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output uop_t            uop,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        uop        = '0;
        uop.alu_op = ALU_NOP;
        imm        = '0;
        legal      = 1'b0;

        case (opcode)
            OPC_R: begin
                uop.rd           = inst[11:7];
                uop.rs1          = inst[19:15];
                uop.rs2          = inst[24:20];
                uop.rs2_en       = 1'b1;
                uop.reg_write_en = 1'b1;
                legal            = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'd0:    uop.alu_op = ALU_ADD;
                        3'd1:    uop.alu_op = ALU_SLL;
                        3'd2:    uop.alu_op = ALU_SLT;
                        3'd3:    uop.alu_op = ALU_SLTU;
                        3'd4:    uop.alu_op = ALU_XOR;
                        3'd5:    uop.alu_op = ALU_SRL;
                        3'd6:    uop.alu_op = ALU_OR;
                        default: uop.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    uop.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    uop.alu_op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC_I: begin
                uop.rd           = inst[11:7];
                uop.rs1          = inst[19:15];
                uop.reg_write_en = 1'b1;
                imm              = {{(XLEN-12){inst[31]}}, inst[31:20]};
                legal            = 1'b1;
                case (funct3)
                    3'd0: uop.alu_op = ALU_ADD;
                    3'd1: begin
                        uop.alu_op = ALU_SLL;
                        legal      = (funct7 == F7_BASE);
                    end
                    3'd2: uop.alu_op = ALU_SLT;
                    3'd3: uop.alu_op = ALU_SLTU;
                    3'd4: uop.alu_op = ALU_XOR;
                    3'd5: begin
                        // SRAI vs SRLI is carried by inst[30] alone.
                        uop.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                        legal      = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'd6:    uop.alu_op = ALU_OR;
                    default: uop.alu_op = ALU_AND;
                endcase
            end

            OPC_LOAD: begin
                uop.alu_op       = ALU_ADD;
                uop.rd           = inst[11:7];
                uop.rs1          = inst[19:15];
                uop.reg_write_en = 1'b1;
                uop.mem_read_en  = 1'b1;
                uop.mem_size     = mem_size_t'(funct3);
                imm              = {{(XLEN-12){inst[31]}}, inst[31:20]};
                legal            = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end

            OPC_STORE: begin
                uop.alu_op       = ALU_ADD;
                uop.rs1          = inst[19:15];
                uop.rs2          = inst[24:20];
                uop.rs2_en       = 1'b1;
                uop.mem_write_en = 1'b1;
                uop.mem_size     = mem_size_t'(funct3);
                imm              = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
                legal            = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end

            OPC_BRANCH: begin
                uop.alu_op    = ALU_SUB;
                uop.rs1       = inst[19:15];
                uop.rs2       = inst[24:20];
                uop.rs2_en    = 1'b1;
                uop.branch_en = 1'b1;
                uop.br_cond   = funct3;
                imm           = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                legal         = (funct3 != 3'd2) && (funct3 != 3'd3);
            end

            default: legal = 1'b0;
        endcase

        if (!legal) begin
            uop         = '0;
            uop.alu_op  = ALU_NOP;
            uop.illegal = 1'b1;
            imm         = '0;
        end

        if (uop.rd == 5'd0) begin
            uop.reg_write_en = 1'b0;
        end
    end

endmodule

// File: rtl/dual_issue_decode_stage.sv
// Registered 2-wide decode/issue stage. Decodes an in-order pair (A older,
// B younger), issues both together when the pairing rules allow it, and
// otherwise issues A first and B from a holding register on a later cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     drop all in-flight decode state
//   in_valid / in_ready       fetch-side handshake for the pair
//   inst_a, inst_b, pc_in     pair and PC of inst_a (inst_b is pc_in+4)
//   out_ready                 execute lanes accept the current outputs
//   out_valid_a/b             lane valids (A: ALU/branch, B: ALU/load/store)
//   uop_a/b, imm_a/b, pc_a/b  per-lane micro-op, immediate and PC
module dual_issue_decode_stage
    import dec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_W        = 32,
    parameter int DUAL_ISSUE  = 1,
    parameter int BRANCH_PAIR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_a,
    input  logic [31:0]     inst_b,
    input  logic [PC_W-1:0] pc_in,
    input  logic            out_ready,
    output logic            out_valid_a,
    output logic            out_valid_b,
    output uop_t            uop_a,
    output uop_t            uop_b,
    output logic [XLEN-1:0] imm_a,
    output logic [XLEN-1:0] imm_b,
    output logic [PC_W-1:0] pc_a,
    output logic [PC_W-1:0] pc_b
);

    // state | meaning
    // IDLE  | accepting pairs
    // HOLD  | younger instruction of a split pair waits in the hold register
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam bit DUAL_EN   = (DUAL_ISSUE != 0);
    localparam bit BR_PAIREN = (BRANCH_PAIR != 0);

    logic [0:0]      state_q, state_nxt;
    uop_t            dec_a, dec_b;
    logic [XLEN-1:0] dec_imm_a, dec_imm_b;

    uop_t            hold_uop_q;
    logic [XLEN-1:0] hold_imm_q;
    logic [PC_W-1:0] hold_pc_q;

    logic            out_free;
    logic            accept;
    logic            raw_hz, waw_hz, split;

    uop_t            sgl_uop;
    logic [XLEN-1:0] sgl_imm;
    logic [PC_W-1:0] sgl_pc;

    logic            load_out, latch_b;
    logic            nxt_va, nxt_vb;
    uop_t            nxt_uop_a, nxt_uop_b;
    logic [XLEN-1:0] nxt_imm_a, nxt_imm_b;
    logic [PC_W-1:0] nxt_pc_a, nxt_pc_b;

    rv32_inst_decode #(.XLEN(XLEN)) u_dec_a (
        .inst (inst_a),
        .uop  (dec_a),
        .imm  (dec_imm_a)
    );

    rv32_inst_decode #(.XLEN(XLEN)) u_dec_b (
        .inst (inst_b),
        .uop  (dec_b),
        .imm  (dec_imm_b)
    );

    assign out_free = !(out_valid_a || out_valid_b) || out_ready;
    assign in_ready = (state_q == IDLE) && out_free;
    assign accept   = in_valid && in_ready && !flush;

    // rs1 is read by every legal class; an illegal B has rs1=0, and A.rd is
    // nonzero whenever A writes, so the rs1 compare needs no enable.
    assign raw_hz = dec_a.reg_write_en &&
                    ((dec_b.rs1 == dec_a.rd) || (dec_b.rs2_en && (dec_b.rs2 == dec_a.rd)));
    assign waw_hz = dec_a.reg_write_en && dec_b.reg_write_en && (dec_b.rd == dec_a.rd);

    assign split = !DUAL_EN || is_mem_op(dec_a) || dec_a.illegal || dec_b.illegal ||
                   dec_b.branch_en || raw_hz || waw_hz || (dec_a.branch_en && !BR_PAIREN);

    // A lone instruction comes from the hold register in HOLD, else from A.
    assign sgl_uop = (state_q == HOLD) ? hold_uop_q : dec_a;
    assign sgl_imm = (state_q == HOLD) ? hold_imm_q : dec_imm_a;
    assign sgl_pc  = (state_q == HOLD) ? hold_pc_q  : pc_in;

    always_comb begin
        state_nxt = state_q;
        load_out  = 1'b0;
        latch_b   = 1'b0;
        nxt_va    = 1'b0;
        nxt_vb    = 1'b0;
        nxt_uop_a = '0;
        nxt_uop_b = '0;
        nxt_imm_a = '0;
        nxt_imm_b = '0;
        nxt_pc_a  = '0;
        nxt_pc_b  = '0;

        if ((state_q == HOLD && out_free) || (accept && split)) begin
            load_out  = 1'b1;
            latch_b   = (state_q == IDLE);
            state_nxt = (state_q == IDLE) ? HOLD : IDLE;
            if (is_mem_op(sgl_uop)) begin
                nxt_vb    = 1'b1;
                nxt_uop_b = sgl_uop;
                nxt_imm_b = sgl_imm;
                nxt_pc_b  = sgl_pc;
            end else begin
                nxt_va    = 1'b1;
                nxt_uop_a = sgl_uop;
                nxt_imm_a = sgl_imm;
                nxt_pc_a  = sgl_pc;
            end
        end else if (accept) begin
            load_out  = 1'b1;
            nxt_va    = 1'b1;
            nxt_vb    = 1'b1;
            nxt_uop_a = dec_a;
            nxt_uop_b = dec_b;
            nxt_imm_a = dec_imm_a;
            nxt_imm_b = dec_imm_b;
            nxt_pc_a  = pc_in;
            nxt_pc_b  = pc_in + PC_W'(4);
        end else if (state_q == IDLE && out_free) begin
            // Current outputs consumed with nothing new to issue: clear lanes.
            load_out = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_a <= 1'b0;
            out_valid_b <= 1'b0;
            uop_a       <= '0;
            uop_b       <= '0;
            imm_a       <= '0;
            imm_b       <= '0;
            pc_a        <= '0;
            pc_b        <= '0;
            hold_uop_q  <= '0;
            hold_imm_q  <= '0;
            hold_pc_q   <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_a <= 1'b0;
            out_valid_b <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (load_out) begin
                out_valid_a <= nxt_va;
                out_valid_b <= nxt_vb;
                uop_a       <= nxt_uop_a;
                uop_b       <= nxt_uop_b;
                imm_a       <= nxt_imm_a;
                imm_b       <= nxt_imm_b;
                pc_a        <= nxt_pc_a;
                pc_b        <= nxt_pc_b;
            end
            if (latch_b) begin
                hold_uop_q <= dec_b;
                hold_imm_q <= dec_imm_b;
                hold_pc_q  <= pc_in + PC_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_decode_stage.sv
module tb_dual_issue_decode_stage;
    import dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] inst_a = '0, inst_b = '0, pc_in = '0;

    logic        ir0, va0, vb0, ir1, va1, vb1;
    uop_t        uop_a0, uop_b0, uop_a1, uop_b1;
    logic [31:0] imm_a0, imm_b0, pc_a0, pc_b0;
    logic [31:0] imm_a1, imm_b1, pc_a1, pc_b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_issue_decode_stage #(.XLEN(32), .PC_W(32), .DUAL_ISSUE(1), .BRANCH_PAIR(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .inst_a(inst_a), .inst_b(inst_b), .pc_in(pc_in), .out_ready(out_ready),
        .out_valid_a(va0), .out_valid_b(vb0), .uop_a(uop_a0), .uop_b(uop_b0),
        .imm_a(imm_a0), .imm_b(imm_b0), .pc_a(pc_a0), .pc_b(pc_b0));

    dual_issue_decode_stage #(.XLEN(32), .PC_W(32), .DUAL_ISSUE(0), .BRANCH_PAIR(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .inst_a(inst_a), .inst_b(inst_b), .pc_in(pc_in), .out_ready(out_ready),
        .out_valid_a(va1), .out_valid_b(vb1), .uop_a(uop_a1), .uop_b(uop_b1),
        .imm_a(imm_a1), .imm_b(imm_b1), .pc_a(pc_a1), .pc_b(pc_b1));

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        uop_t        u;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        int          inst;
        bit          va, vb;
        uop_t        ua, ub;
        logic [31:0] ia, ib, pa, pb;
    } bundle_t;

    // funct7=0 R-type / I-type op by funct3: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [3:0] BASE_OPS [8] = '{4'd0, 4'd2, 4'd8, 4'd9, 4'd3, 4'd4, 4'd6, 4'd7};

    bundle_t q[$];

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        d.u = '0; d.imm = '0; ok = 1'b0;
        if (op == 7'b0110011) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            d.u.alu_op = alu_op_t'((f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd5) : BASE_OPS[f3]);
            d.u.rd = i[11:7]; d.u.rs1 = i[19:15]; d.u.rs2 = i[24:20];
            d.u.rs2_en = 1'b1; d.u.reg_write_en = 1'b1;
        end else if (op == 7'b0010011) begin
            ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            d.u.alu_op = alu_op_t'((f3 == 3'd5 && i[30]) ? 4'd5 : BASE_OPS[f3]);
            d.u.rd = i[11:7]; d.u.rs1 = i[19:15]; d.u.reg_write_en = 1'b1;
            d.imm = 32'(signed'(i[31:20]));
        end else if (op == 7'b0000011) begin
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            d.u.rd = i[11:7]; d.u.rs1 = i[19:15]; d.u.reg_write_en = 1'b1;
            d.u.mem_read_en = 1'b1; d.u.mem_size = mem_size_t'(f3);
            d.imm = 32'(signed'(i[31:20]));
        end else if (op == 7'b0100011) begin
            ok = !(f3 inside {3'd3, 3'd6, 3'd7});
            d.u.rs1 = i[19:15]; d.u.rs2 = i[24:20]; d.u.rs2_en = 1'b1;
            d.u.mem_write_en = 1'b1; d.u.mem_size = mem_size_t'(f3);
            d.imm = 32'(signed'({i[31:25], i[11:7]}));
        end else if (op == 7'b1100011) begin
            ok = !(f3 inside {3'd2, 3'd3});
            d.u.alu_op = alu_op_t'(4'd1);
            d.u.rs1 = i[19:15]; d.u.rs2 = i[24:20]; d.u.rs2_en = 1'b1;
            d.u.branch_en = 1'b1; d.u.br_cond = f3;
            d.imm = 32'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        end
        if (!ok) begin
            d.u = '0; d.u.alu_op = alu_op_t'(4'hF); d.u.illegal = 1'b1; d.imm = '0;
        end
        if (d.u.rd == 5'd0) d.u.reg_write_en = 1'b0;
        return d;
    endfunction

    function automatic bundle_t single(input int k, input dec_t d, input logic [31:0] pc);
        bundle_t b;
        b.inst = k; b.va = 0; b.vb = 0; b.ua = '0; b.ub = '0;
        b.ia = '0; b.ib = '0; b.pa = '0; b.pb = '0;
        if (d.u.mem_read_en || d.u.mem_write_en) begin
            b.vb = 1; b.ub = d.u; b.ib = d.imm; b.pb = pc;
        end else begin
            b.va = 1; b.ua = d.u; b.ia = d.imm; b.pa = pc;
        end
        return b;
    endfunction

    task automatic model_accept(input int k, input bit dual, input logic [31:0] a, b, pc);
        dec_t da, db;
        bit hazard, pair;
        bundle_t bb;
        da = ref_decode(a);
        db = ref_decode(b);
        hazard = da.u.reg_write_en && ((db.u.rs1 == da.u.rd) ||
                 (db.u.rs2_en && db.u.rs2 == da.u.rd) ||
                 (db.u.reg_write_en && db.u.rd == da.u.rd));
        pair = dual && !da.u.mem_read_en && !da.u.mem_write_en && !da.u.illegal &&
               !db.u.illegal && !db.u.branch_en && !hazard;
        if (pair) begin
            bb.inst = k; bb.va = 1; bb.vb = 1; bb.ua = da.u; bb.ub = db.u;
            bb.ia = da.imm; bb.ib = db.imm; bb.pa = pc; bb.pb = pc + 32'd4;
            q.push_back(bb);
        end else begin
            q.push_back(single(k, da, pc));
            q.push_back(single(k, db, pc + 32'd4));
        end
    endtask

    function automatic int first_of(input int k);
        foreach (q[n]) if (q[n].inst == k) return n;
        return -1;
    endfunction

    function automatic int count_of(input int k);
        int c = 0;
        foreach (q[n]) if (q[n].inst == k) c++;
        return c;
    endfunction

    task automatic compare(input int k, input logic ir, va, vb, input uop_t ua, ub,
                           input logic [31:0] ia, ib, pa, pb);
        int idx, n;
        bit exp_ir;
        string p;
        p = $sformatf("d%0d", k);
        idx = first_of(k);
        n = count_of(k);
        exp_ir = (n == 0) || (n == 1 && out_ready);
        chk(ir === exp_ir, {p, ".in_ready"}, 64'(ir), 64'(exp_ir));
        if (idx < 0) begin
            chk(va === 1'b0 && vb === 1'b0, {p, ".valid_idle"}, {va, vb}, 0);
        end else begin
            chk(va === q[idx].va, {p, ".out_valid_a"}, 64'(va), 64'(q[idx].va));
            chk(vb === q[idx].vb, {p, ".out_valid_b"}, 64'(vb), 64'(q[idx].vb));
            if (q[idx].va) begin
                chk(ua === q[idx].ua, {p, ".uop_a"}, 64'(ua), 64'(q[idx].ua));
                chk(ia === q[idx].ia, {p, ".imm_a"}, 64'(ia), 64'(q[idx].ia));
                chk(pa === q[idx].pa, {p, ".pc_a"}, 64'(pa), 64'(q[idx].pa));
            end
            if (q[idx].vb) begin
                chk(ub === q[idx].ub, {p, ".uop_b"}, 64'(ub), 64'(q[idx].ub));
                chk(ib === q[idx].ib, {p, ".imm_b"}, 64'(ib), 64'(q[idx].ib));
                chk(pb === q[idx].pb, {p, ".pc_b"}, 64'(pb), 64'(q[idx].pb));
            end
        end
    endtask

    task automatic step(input int k, input bit iv, input bit dual);
        int idx, n;
        bit exp_ir;
        if (flush) begin
            for (int j = q.size() - 1; j >= 0; j--) if (q[j].inst == k) q.delete(j);
        end else begin
            idx = first_of(k);
            n = count_of(k);
            exp_ir = (n == 0) || (n == 1 && out_ready);
            if (idx >= 0 && out_ready) q.delete(idx);
            if (iv && exp_ir) model_accept(k, dual, inst_a, inst_b, pc_in);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            compare(0, ir0, va0, vb0, uop_a0, uop_b0, imm_a0, imm_b0, pc_a0, pc_b0);
            compare(1, ir1, va1, vb1, uop_a1, uop_b1, imm_a1, imm_b1, pc_a1, pc_b1);
            step(0, iv0, 1'b1);
            step(1, iv1, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int k, input logic [31:0] a, b, pc);
        int n;
        bit done;
        inst_a = a; inst_b = b; pc_in = pc;
        if (k == 0) iv0 = 1'b1; else iv1 = 1'b1;
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if ((k == 0) ? ir0 : ir1) done = 1;
            else begin
                n++;
                if (n >= 40) begin
                    chk(1'b0, "send_timeout", 64'(n), 40);
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk(va0 === 1'b0 && vb0 === 1'b0, "rst.valid", {va0, vb0}, 0);
        chk(uop_a0 === '0 && uop_b0 === '0, "rst.uop", {uop_a0, uop_b0}, 0);
        chk(imm_a0 === '0 && imm_b0 === '0, "rst.imm", {imm_a0, imm_b0}, 0);
        chk(pc_a0 === '0 && pc_b0 === '0, "rst.pc", {pc_a0, pc_b0}, 0);
        chk(ir0 === 1'b1, "rst.in_ready", 64'(ir0), 1);
        tick(); rst = 1'b0;
        tick();

        // add x1,x2,x3 + addi x6,x0,5: dual issue
        send(0, 32'h003100B3, 32'h00500313, 32'h100);
        chk(va0 && vb0, "pair.valid", {va0, vb0}, 3);
        chk(uop_b0.alu_op == ALU_ADD, "pair.alu_op_b", 64'(uop_b0.alu_op), 0);
        chk(imm_b0 == 32'd5, "pair.imm_b", imm_b0, 5);
        chk(uop_b0.rd == 5'd6, "pair.rd_b", 64'(uop_b0.rd), 6);

        // RAW on x1
        send(0, 32'h003100B3, 32'h00508233, 32'h200);
        chk(va0 && !vb0 && uop_a0.rd == 5'd1, "raw.c1", {va0, vb0, uop_a0.rd}, {1'b1, 1'b0, 5'd1});
        chk(ir0 === 1'b0, "raw.c1_in_ready", 64'(ir0), 0);
        tick();
        chk(va0 && !vb0 && uop_a0.rd == 5'd4, "raw.c2", {va0, vb0, uop_a0.rd}, {1'b1, 1'b0, 5'd4});
        chk(pc_a0 == 32'h204, "raw.c2_pc", pc_a0, 32'h204);

        // beq + lw paired
        send(0, 32'h00208463, 32'h00012383, 32'h300);
        chk(va0 && vb0 && uop_a0.branch_en, "br.branch_en_a", {va0, vb0, uop_a0.branch_en}, 7);
        chk(imm_a0 == 32'd8, "br.imm_a", imm_a0, 8);
        chk(uop_b0.mem_read_en && uop_b0.mem_size == MEM_W, "br.lw_b",
            {uop_b0.mem_read_en, uop_b0.mem_size}, {1'b1, 3'd2});
        chk(pc_b0 == 32'h304, "br.pc_b", pc_b0, 32'h304);

        // backpressure: hold add x1 + sw x5,4(x2) for 3 cycles
        tick();
        out_ready = 1'b0;
        send(0, 32'h003100B3, 32'h00512223, 32'h400);
        inst_a = 32'h00500313; inst_b = 32'h4020D093; pc_in = 32'h480; iv0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk(ir0 === 1'b0, "bp.in_ready", 64'(ir0), 0);
            chk(va0 && vb0 && uop_a0.rd == 5'd1 && uop_b0.mem_write_en && imm_b0 == 32'd4,
                "bp.stable", {va0, vb0, uop_a0.rd, uop_b0.mem_write_en, imm_b0}, {2'b11, 5'd1, 1'b1, 32'd4});
        end
        tick();
        out_ready = 1'b1;
        send(0, 32'h00500313, 32'h4020D093, 32'h480);
        chk(va0 && vb0 && uop_b0.alu_op == ALU_SRA, "bp.next_pair", {va0, vb0, uop_b0.alu_op}, {2'b11, 4'd5});

        // flush during HOLD
        send(0, 32'h003100B3, 32'h00508233, 32'h700);
        inst_a = 32'h00500313; inst_b = 32'h00100093; pc_in = 32'h780;
        iv0 = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; iv0 = 1'b0;
        chk(!va0 && !vb0, "flush.valid", {va0, vb0}, 0);
        chk(ir0 === 1'b1, "flush.in_ready", 64'(ir0), 1);
        repeat (3) begin
            tick();
            chk(!va0 && !vb0, "flush.no_b", {va0, vb0}, 0);
        end

        // illegal opcode in A
        send(0, 32'h0000007F, 32'h00500313, 32'h500);
        chk(va0 && !vb0 && uop_a0.illegal && !uop_a0.reg_write_en, "ill.a",
            {va0, vb0, uop_a0.illegal, uop_a0.reg_write_en}, 4'b1010);
        tick();
        chk(va0 && uop_a0.rd == 5'd6 && pc_a0 == 32'h504, "ill.then_b", {va0, uop_a0.rd, pc_a0}, {1'b1, 5'd6, 32'h504});

        // load in A goes to lane B alone
        send(0, 32'h00012383, 32'h003100B3, 32'h600);
        chk(!va0 && vb0 && pc_b0 == 32'h600, "lda.lane_b", {va0, vb0, pc_b0}, {2'b01, 32'h600});

        // WAW, branch in B, store in B pairing: model-checked
        send(0, 32'h003100B3, 32'h00100093, 32'h800);
        send(0, 32'h003100B3, 32'h00208463, 32'h900);
        send(0, 32'h00500313, 32'h00512223, 32'hA00);

        // async reset in the middle of a split
        send(0, 32'h003100B3, 32'h00508233, 32'hB00);
        #2 rst = 1'b1;
        #1;
        chk(!va0 && !vb0 && ir0 === 1'b1, "arst.clear", {va0, vb0, ir0}, 1);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk(!va0 && !vb0, "arst.no_b", {va0, vb0}, 0);
        end

        // scalar instance: every pair splits
        send(1, 32'h003100B3, 32'h00500313, 32'h100);
        chk(va1 && !vb1 && uop_a1.rd == 5'd1, "scal.c1", {va1, vb1, uop_a1.rd}, {2'b10, 5'd1});
        tick();
        chk(va1 && !vb1 && uop_a1.rd == 5'd6 && imm_a1 == 32'd5, "scal.c2",
            {va1, vb1, uop_a1.rd, imm_a1}, {2'b10, 5'd6, 32'd5});
        send(1, 32'h00208463, 32'h00012383, 32'h300);
        send(1, 32'h00500313, 32'h00512223, 32'hA00);

        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
